// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RV32I datapath with shared instruction/data memory.
// Sequences one instruction over several cycles and drives every datapath enable and mux select.
// Optional feature: define MC_ILLEGAL_HALT_EN to trap unknown opcodes in a HALT state that
// raises the extra output port halt; otherwise unknown opcodes retire as a NOP.
module multicycle_controller #(
  parameter int unsigned FETCH_WAIT = 0,
  parameter int unsigned MEM_WAIT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       instr_done
`ifdef MC_ILLEGAL_HALT_EN
  ,
  output logic       halt
`endif
);

  localparam int unsigned MaxWait = (FETCH_WAIT > MEM_WAIT) ? FETCH_WAIT : MEM_WAIT;
  localparam int unsigned CntW    = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
  localparam logic [CntW-1:0] FetchLast = CntW'(FETCH_WAIT);
  localparam logic [CntW-1:0] MemLast   = CntW'(MEM_WAIT);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcAReg   = 2'b10;
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  localparam logic [1:0] ResImm       = 2'b11;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b100;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StAluWb, StBranch, StJal, StJalrA, StJalrB, StLui, StHalt
  } state_t;

  state_t          r_state, w_state_d;
  logic [CntW-1:0] r_cnt;
  logic            w_fetch_last, w_mem_last;
  logic            w_unused_funct7;

  assign w_fetch_last    = (r_cnt == FetchLast);
  assign w_mem_last      = (r_cnt == MemLast);
  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  // funct3 -> ALU operation for register and immediate arithmetic
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_dec = sub ? AluSub : AluAdd;
      3'b111:  alu_dec = AluAnd;
      3'b110:  alu_dec = AluOr;
      3'b010:  alu_dec = AluSlt;
      default: alu_dec = AluAdd;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StFetch;
    else     r_state <= w_state_d;
  end

  // Stall counter: restarts on every state change, counts while a wait state holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_state_d != r_state) begin
      r_cnt <= '0;
    end else if (r_state inside {StFetch, StMemRead, StMemWrite}) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_state_d   = r_state;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = ResAluOut;
    alu_src_a   = SrcAPc;
    alu_src_b   = SrcBReg;
    alu_control = AluAdd;
    imm_src     = ImmI;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
`ifdef MC_ILLEGAL_HALT_EN
    halt        = 1'b0;
`endif
    case (r_state)
      StFetch: begin
        alu_src_a = SrcAPc;
        alu_src_b = SrcBFour;
        if (w_fetch_last) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          result_src = ResAluResult;
          w_state_d  = StDecode;
        end
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        imm_src   = ImmB;
        case (op)
          OpLoad, OpStore: w_state_d = StMemAdr;
          OpRType:         w_state_d = StExecR;
          OpIType:         w_state_d = StExecI;
          OpBranch:        w_state_d = StBranch;
          OpJal:           w_state_d = StJal;
          OpJalr:          w_state_d = StJalrA;
          OpLui:           w_state_d = StLui;
          default: begin
`ifdef MC_ILLEGAL_HALT_EN
            w_state_d = StHalt;
`else
            w_state_d  = StFetch;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        // op[5] separates store (0100011) from load (0000011)
        imm_src   = op[5] ? ImmS : ImmI;
        w_state_d = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (w_mem_last) w_state_d = StMemWb;
      end
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_state_d  = StFetch;
      end
      StMemWrite: begin
        adr_src = 1'b1;
        if (w_mem_last) begin
          mem_write  = 1'b1;
          instr_done = 1'b1;
          w_state_d  = StFetch;
        end
      end
      StExecR: begin
        alu_src_a   = SrcAReg;
        alu_src_b   = SrcBReg;
        alu_control = alu_dec(funct3, funct7[5]);
        w_state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a   = SrcAReg;
        alu_src_b   = SrcBImm;
        imm_src     = ImmI;
        alu_control = alu_dec(funct3, 1'b0);
        w_state_d   = StAluWb;
      end
      StAluWb: begin
        result_src = ResAluOut;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_state_d  = StFetch;
      end
      StBranch: begin
        alu_src_a  = SrcAReg;
        alu_src_b  = SrcBReg;
        result_src = ResAluOut;
        instr_done = 1'b1;
        w_state_d  = StFetch;
        // blt/bge use slt: zero=0 means rs1<rs2
        case (funct3)
          3'b000: begin alu_control = AluSub; pc_write = zero;  end
          3'b001: begin alu_control = AluSub; pc_write = ~zero; end
          3'b100: begin alu_control = AluSlt; pc_write = ~zero; end
          3'b101: begin alu_control = AluSlt; pc_write = zero;  end
          default: ;
        endcase
      end
      StJal: begin
        alu_src_a  = SrcAOldPc;
        alu_src_b  = SrcBFour;
        result_src = ResAluOut;
        pc_write   = 1'b1;
        w_state_d  = StAluWb;
      end
      StJalrA: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        imm_src   = ImmI;
        w_state_d = StJalrB;
      end
      StJalrB: begin
        result_src = ResAluOut;
        pc_write   = 1'b1;
        alu_src_a  = SrcAOldPc;
        alu_src_b  = SrcBFour;
        w_state_d  = StAluWb;
      end
      StLui: begin
        imm_src    = ImmU;
        result_src = ResImm;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_state_d  = StFetch;
      end
`ifdef MC_ILLEGAL_HALT_EN
      StHalt: begin
        halt = 1'b1;
      end
`endif
      default: w_state_d = StFetch;
    endcase
    // Reset aborts the instruction with no side effects, even mid-cycle
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three instances with different stall settings, each
// checked cycle by cycle against an instruction-level model of the control outputs.
module tb_multicycle_controller;
  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst         [NDUT];
  logic [6:0] op          [NDUT];
  logic [2:0] f3          [NDUT];
  logic [6:0] f7          [NDUT];
  logic       zero        [NDUT];
  logic       pc_write    [NDUT];
  logic       adr_src     [NDUT];
  logic       mem_write   [NDUT];
  logic       ir_write    [NDUT];
  logic       reg_write   [NDUT];
  logic       instr_done  [NDUT];
  logic [1:0] result_src  [NDUT];
  logic [1:0] alu_src_a   [NDUT];
  logic [1:0] alu_src_b   [NDUT];
  logic [2:0] alu_control [NDUT];
  logic [2:0] imm_src     [NDUT];
`ifdef MC_ILLEGAL_HALT_EN
  logic       halt_o      [NDUT];
`endif

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    multicycle_controller #(
      .FETCH_WAIT((g == 2) ? 2 : 0),
      .MEM_WAIT  ((g == 1) ? 2 : ((g == 2) ? 1 : 0))
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .op         (op[g]),
      .funct3     (f3[g]),
      .funct7     (f7[g]),
      .zero       (zero[g]),
      .pc_write   (pc_write[g]),
      .adr_src    (adr_src[g]),
      .mem_write  (mem_write[g]),
      .ir_write   (ir_write[g]),
      .result_src (result_src[g]),
      .alu_src_a  (alu_src_a[g]),
      .alu_src_b  (alu_src_b[g]),
      .alu_control(alu_control[g]),
      .imm_src    (imm_src[g]),
      .reg_write  (reg_write[g]),
      .instr_done (instr_done[g])
`ifdef MC_ILLEGAL_HALT_EN
      ,
      .halt       (halt_o[g])
`endif
    );
  end

  function automatic int fw_of(int d);
    return (d == 2) ? 2 : 0;
  endfunction

  function automatic int mw_of(int d);
    return (d == 1) ? 2 : ((d == 2) ? 1 : 0);
  endfunction

  function automatic logic is_legal(logic [6:0] o);
    return o inside {LW, SW, RT, IT, BR, JAL, JALR, LUI};
  endfunction

  function automatic logic [17:0] mk(logic pcw, logic adr, logic memw, logic irw,
                                     logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                     logic [2:0] alu, logic [2:0] imm, logic rw, logic done);
    return {pcw, adr, memw, irw, rs, a, b, alu, imm, rw, done};
  endfunction

  function automatic logic [17:0] obs(int d);
    return mk(pc_write[d], adr_src[d], mem_write[d], ir_write[d], result_src[d], alu_src_a[d],
              alu_src_b[d], alu_control[d], imm_src[d], reg_write[d], instr_done[d]);
  endfunction

  function automatic logic [2:0] alu_ref(logic [2:0] fn3, logic sub);
    case (fn3)
      3'd0:    return sub ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd2:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Expected per-cycle outputs for one instruction, from the instruction's phase list
  function automatic void build_exp(int fw, int mw, logic [6:0] o, logic [2:0] fn3,
                                    logic [6:0] fn7, logic z);
    logic [17:0] wb;
    logic [2:0]  balu;
    logic        take;
    exp_q.delete();
    wb = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1, 1);
    for (int i = 0; i <= fw; i++)
      exp_q.push_back((i == fw) ? mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 0, 0)
                                : mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 3'd0, 3'd0, 0, 0));
`ifdef MC_ILLEGAL_HALT_EN
    exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, 3'd2, 0, 0));
`else
    exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, 3'd2, 0, !is_legal(o)));
`endif
    case (o)
      LW: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 3'd0, 0, 0));
        for (int i = 0; i <= mw; i++)
          exp_q.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'd0, 3'd0, 1, 1));
      end
      SW: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 3'd1, 0, 0));
        for (int i = 0; i <= mw; i++)
          exp_q.push_back(mk(0, 1, i == mw, 0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 0, i == mw));
      end
      RT: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_ref(fn3, fn7[5]), 3'd0, 0, 0));
        exp_q.push_back(wb);
      end
      IT: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_ref(fn3, 1'b0), 3'd0, 0, 0));
        exp_q.push_back(wb);
      end
      BR: begin
        case (fn3)
          3'd0:    begin balu = 3'd1; take = z;  end
          3'd1:    begin balu = 3'd1; take = !z; end
          3'd4:    begin balu = 3'd4; take = !z; end
          3'd5:    begin balu = 3'd4; take = z;  end
          default: begin balu = 3'd0; take = 0;  end
        endcase
        exp_q.push_back(mk(take, 0, 0, 0, 2'b00, 2'b10, 2'b00, balu, 3'd0, 0, 1));
      end
      JAL: begin
        exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, 3'd0, 0, 0));
        exp_q.push_back(wb);
      end
      JALR: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 3'd0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, 3'd0, 0, 0));
        exp_q.push_back(wb);
      end
      LUI: exp_q.push_back(mk(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'd0, 3'd4, 1, 1));
      default: begin
`ifdef MC_ILLEGAL_HALT_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(18'd0);
`endif
      end
    endcase
  endfunction

  // Entered at a falling edge with the DUT in its first FETCH cycle; leaves the same way
  task automatic run_instr(input int d, input logic [6:0] o, input logic [2:0] fn3,
                           input logic [6:0] fn7, input logic z, input string name);
    logic [17:0] got;
    int          n;
    build_exp(fw_of(d), mw_of(d), o, fn3, fn7, z);
    n = exp_q.size();
    op[d] = o; f3[d] = fn3; f7[d] = fn7; zero[d] = z;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      got = obs(d);
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL %s dut%0d cycle%0d: got=%05h want=%05h", name, d, i, got, exp_q[i]);
      end
`ifdef MC_ILLEGAL_HALT_EN
      begin
        logic want_h;
        want_h = !is_legal(o) && (i >= fw_of(d) + 2);
        total++;
        if (halt_o[d] !== want_h) begin
          bad++;
          $display("FAIL %s_halt dut%0d cycle%0d: got=%b want=%b", name, d, i, halt_o[d], want_h);
        end
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; op[d] = '0; f3[d] = '0; f7[d] = '0; zero[d] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({pc_write[d], ir_write[d], reg_write[d], mem_write[d], instr_done[d]} !== 5'b0) begin
          bad++;
          $display("FAIL reset_enables dut%0d: got=%b want=00000", d,
                   {pc_write[d], ir_write[d], reg_write[d], mem_write[d], instr_done[d]});
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
  endtask

  task automatic test_alu_ops();
    do_reset(0);
    run_instr(0, RT, 3'd0, 7'h00, 0, "add");
    run_instr(0, RT, 3'd0, 7'h20, 0, "sub");
    run_instr(0, RT, 3'd7, 7'h00, 0, "and");
    run_instr(0, RT, 3'd6, 7'h00, 1, "or");
    run_instr(0, RT, 3'd2, 7'h00, 0, "slt");
    run_instr(0, RT, 3'd1, 7'h20, 0, "r_bad_f3");
    run_instr(0, IT, 3'd0, 7'h20, 0, "addi_f7_ignored");
    run_instr(0, IT, 3'd7, 7'h00, 0, "andi");
    run_instr(0, IT, 3'd6, 7'h00, 0, "ori");
    run_instr(0, IT, 3'd2, 7'h00, 0, "slti");
    run_instr(0, IT, 3'd5, 7'h00, 0, "i_bad_f3");
    do_reset(2);
    run_instr(2, RT, 3'd0, 7'h20, 0, "sub_fetchwait");
  endtask

  task automatic test_load_store();
    for (int d = 0; d < NDUT; d++) begin
      do_reset(d);
      run_instr(d, LW, 3'd2, 7'h00, 0, "lw");
      run_instr(d, SW, 3'd2, 7'h00, 0, "sw");
      run_instr(d, LW, 3'd2, 7'h00, 1, "lw_again");
    end
  endtask

  task automatic test_branch();
    do_reset(0);
    for (int z = 0; z < 2; z++) begin
      run_instr(0, BR, 3'd0, 7'h00, z[0], "beq");
      run_instr(0, BR, 3'd1, 7'h00, z[0], "bne");
      run_instr(0, BR, 3'd4, 7'h00, z[0], "blt");
      run_instr(0, BR, 3'd5, 7'h00, z[0], "bge");
      run_instr(0, BR, 3'd2, 7'h00, z[0], "br_bad_f3");
    end
  endtask

  task automatic test_jumps();
    do_reset(0);
    run_instr(0, JAL, 3'd0, 7'h00, 0, "jal");
    run_instr(0, JALR, 3'd0, 7'h00, 0, "jalr");
    run_instr(0, LUI, 3'd3, 7'h7f, 1, "lui");
    do_reset(2);
    run_instr(2, JALR, 3'd0, 7'h00, 0, "jalr_fw2");
    run_instr(2, LUI, 3'd0, 7'h00, 0, "lui_fw2");
  endtask

  // Cycles from first FETCH to instr_done, inclusive
  task automatic count_len(input int d, input logic [6:0] o, input logic [2:0] fn3,
                           input logic z, input int want, input string name);
    int n;
    op[d] = o; f3[d] = fn3; f7[d] = 7'h00; zero[d] = z;
    #1;
    n = 1;
    while (instr_done[d] !== 1'b1 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== want) begin
      bad++;
      $display("FAIL len_%s dut%0d: got=%0d cycles want=%0d", name, d, n, want);
    end
    @(negedge clk);
  endtask

  task automatic test_lengths();
    do_reset(0);
    count_len(0, LUI, 3'd0, 0, 3, "lui");
    count_len(0, BR, 3'd0, 1, 3, "beq");
    count_len(0, BR, 3'd1, 1, 3, "bne");
    count_len(0, RT, 3'd0, 0, 4, "add");
    count_len(0, IT, 3'd0, 0, 4, "addi");
    count_len(0, SW, 3'd2, 0, 4, "sw");
    count_len(0, JAL, 3'd0, 0, 4, "jal");
    count_len(0, LW, 3'd2, 0, 5, "lw");
    count_len(0, JALR, 3'd0, 0, 5, "jalr");
    do_reset(1);
    count_len(1, LW, 3'd2, 0, 7, "lw_memwait2");
  endtask

  task automatic test_reset_midwrite();
    logic [17:0] got;
    do_reset(0);
    op[0] = SW; f3[0] = 3'd2; f7[0] = 7'h00; zero[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (mem_write[0] !== 1'b1) begin
      bad++;
      $display("FAIL memwrite_before_reset: got=%b want=1", mem_write[0]);
    end
    rst[0] = 1'b1;
    #1;
    total++;
    if ({pc_write[0], ir_write[0], reg_write[0], mem_write[0], instr_done[0]} !== 5'b0) begin
      bad++;
      $display("FAIL memwrite_reset_abort: got=%b want=00000",
               {pc_write[0], ir_write[0], reg_write[0], mem_write[0], instr_done[0]});
    end
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    got = obs(0);
    total++;
    if (got !== mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 0, 0)) begin
      bad++;
      $display("FAIL fetch_after_reset: got=%05h want=%05h", got,
               mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 0, 0));
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    do_reset(0);
    run_instr(0, 7'h7f, 3'd0, 7'h00, 0, "illegal_op");
`ifndef MC_ILLEGAL_HALT_EN
    run_instr(0, RT, 3'd0, 7'h00, 0, "after_illegal");
`endif
    do_reset(0);
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    logic [6:0] ill [4];
    logic [6:0] o;
    logic [6:0] fn7;
    int         k;
    ops = '{LW, SW, RT, IT, BR, JAL, JALR, LUI};
    ill = '{7'h7f, 7'h0f, 7'h73, 7'h17};
    for (int d = 0; d < NDUT; d++) begin
      do_reset(d);
      repeat (40) begin
`ifdef MC_ILLEGAL_HALT_EN
        k = $urandom_range(0, 7);
`else
        k = $urandom_range(0, 8);
`endif
        o = (k == 8) ? ill[$urandom_range(0, 3)] : ops[k];
        case ($urandom_range(0, 2))
          0:       fn7 = 7'h00;
          1:       fn7 = 7'h20;
          default: fn7 = 7'($urandom);
        endcase
        run_instr(d, o, 3'($urandom), fn7, 1'($urandom), "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_jumps();
    test_lengths();
    test_reset_midwrite();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
